// File: rtl/comb_logic_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : comb_logic_sweeper
// Brief    : Walks a 4-input combinational block through all 16 input vectors
//            and builds Y1/Y2 truth tables. Optional compare: SWEEP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module comb_logic_sweeper #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        Y1,
    input  logic        Y2,
    output logic        busy,
    output logic        done,
    output logic [3:0]  vec_idx,
    output logic [15:0] tt_y1,
    output logic [15:0] tt_y2
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [15:0] exp_y1,
    input  logic [15:0] exp_y2,
    output logic        mismatch,
    output logic [3:0]  fail_idx,
    output logic [4:0]  fail_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_vec;
    logic [15:0]       r_tt_y1;
    logic [15:0]       r_tt_y2;
    logic              w_start_acc;

    assign w_start_acc = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == c_settle_last) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = (r_vec == 4'hF) ? S_DONE : S_SETTLE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Truth tables are only written in SAMPLE, so they persist through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_vec   <= 4'd0;
            r_tt_y1 <= 16'h0000;
            r_tt_y2 <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_vec   <= 4'd0;
                        r_tt_y1 <= 16'h0000;
                        r_tt_y2 <= 16'h0000;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_settle_last) r_cnt <= '0;
                    else                        r_cnt <= r_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    r_tt_y1[r_vec] <= Y1;
                    r_tt_y2[r_vec] <= Y2;
                    if (r_vec != 4'hF) r_vec <= r_vec + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The vector register drives the datapath pins directly, A as MSB.
    assign {A, B, C, D} = r_vec;
    assign vec_idx      = r_vec;
    assign tt_y1        = r_tt_y1;
    assign tt_y2        = r_tt_y2;
    assign busy         = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done         = (r_state == S_DONE);

`ifdef SWEEP_CHECK_EN
    logic [15:0] r_exp_y1;
    logic [15:0] r_exp_y2;
    logic        r_mismatch;
    logic [3:0]  r_fail_idx;
    logic [4:0]  r_fail_cnt;
    logic        w_vec_fail;

    assign w_vec_fail = (Y1 != r_exp_y1[r_vec]) || (Y2 != r_exp_y2[r_vec]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_y1   <= 16'h0000;
            r_exp_y2   <= 16'h0000;
            r_mismatch <= 1'b0;
            r_fail_idx <= 4'd0;
            r_fail_cnt <= 5'd0;
        end else if (w_start_acc) begin
            r_exp_y1   <= exp_y1;
            r_exp_y2   <= exp_y2;
            r_mismatch <= 1'b0;
            r_fail_idx <= 4'd0;
            r_fail_cnt <= 5'd0;
        end else if (r_state == S_SAMPLE) begin
            if (w_vec_fail) begin
                r_fail_cnt <= r_fail_cnt + 5'd1;
                if (r_fail_cnt == 5'd0) r_fail_idx <= r_vec;
            end
            // Last vector's result is folded in so mismatch is valid in DONE.
            if (r_vec == 4'hF) r_mismatch <= (r_fail_cnt != 5'd0) || w_vec_fail;
        end
    end

    assign mismatch = r_mismatch;
    assign fail_idx = r_fail_idx;
    assign fail_cnt = r_fail_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comb_logic_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_comb_logic_sweeper
// Brief    : Self-checking bench for comb_logic_sweeper with a scoreboard of
//            expected truth tables; DUT0 uses SETTLE_CYC=2, DUT1 SETTLE_CYC=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comb_logic_sweeper;

    typedef struct packed {
        logic [15:0] t1;
        logic [15:0] t2;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic sel;
    logic mode;

    logic        a0, b0, c0, d0, y1_0, y2_0, busy0, done0;
    logic [3:0]  vec0;
    logic [15:0] tt1_0, tt2_0;
    logic        a1, b1, c1, d1, y1_1, y2_1, busy1, done1;
    logic [3:0]  vec1;
    logic [15:0] tt1_1, tt2_1;
    logic        start0, start1;

    logic        cur_busy, cur_done;
    logic [3:0]  cur_vec, cur_abcd;
    logic [15:0] cur_tt1, cur_tt2;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef SWEEP_CHECK_EN
    logic [15:0] exp_y1, exp_y2;
    logic        mm0, mm1;
    logic [3:0]  fidx0, fidx1;
    logic [4:0]  fcnt0, fcnt1;
`endif

    // Stub datapath: mode 0 is Y1=A&B, Y2=C|D; mode 1 is constant Y1=1, Y2=0.
    assign y1_0 = mode ? 1'b1 : (a0 & b0);
    assign y2_0 = mode ? 1'b0 : (c0 | d0);
    assign y1_1 = mode ? 1'b1 : (a1 & b1);
    assign y2_1 = mode ? 1'b0 : (c1 | d1);

    assign start0   = start & ~sel;
    assign start1   = start & sel;
    assign cur_busy = sel ? busy1 : busy0;
    assign cur_done = sel ? done1 : done0;
    assign cur_vec  = sel ? vec1 : vec0;
    assign cur_abcd = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    assign cur_tt1  = sel ? tt1_1 : tt1_0;
    assign cur_tt2  = sel ? tt2_1 : tt2_0;

    comb_logic_sweeper #(.SETTLE_CYC(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .A(a0), .B(b0), .C(c0), .D(d0), .Y1(y1_0), .Y2(y2_0),
        .busy(busy0), .done(done0), .vec_idx(vec0), .tt_y1(tt1_0), .tt_y2(tt2_0)
`ifdef SWEEP_CHECK_EN
        , .exp_y1(exp_y1), .exp_y2(exp_y2),
        .mismatch(mm0), .fail_idx(fidx0), .fail_cnt(fcnt0)
`endif
    );

    comb_logic_sweeper #(.SETTLE_CYC(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .C(c1), .D(d1), .Y1(y1_1), .Y2(y2_1),
        .busy(busy1), .done(done1), .vec_idx(vec1), .tt_y1(tt1_1), .tt_y2(tt2_1)
`ifdef SWEEP_CHECK_EN
        , .exp_y1(exp_y1), .exp_y2(exp_y2),
        .mismatch(mm1), .fail_idx(fidx1), .fail_cnt(fcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one sample after the start-accepting edge; runs until done.
    task automatic watch(input int s);
        int   n      = 0;
        int   busy_n = 0;
        int   per    = s + 1;
        exp_t e;
        while (cur_done !== 1'b1 && n < 400) begin
            if (n < 16 * per) begin
                chk("vec_idx", cur_vec, n / per);
                chk("abcd", cur_abcd, n / per);
            end
            if (cur_busy === 1'b1) busy_n++;
            step();
            n++;
        end
        chk("done_cycle", n + 1, 16 * per + 1);
        chk("busy_cycles", busy_n, 16 * per);
        chk("done_busy", cur_busy, 1'b0);
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("tt_y1", cur_tt1, e.t1);
            chk("tt_y2", cur_tt2, e.t2);
        end
        chk("rest_vec", cur_vec, 4'hF);
        chk("rest_abcd", cur_abcd, 4'hF);
    endtask

    task automatic sweep(input int s, input logic [15:0] e1, input logic [15:0] e2);
        sb_q.push_back(exp_t'({e1, e2}));
        start = 1'b1;
        step();
        start = 1'b0;
        watch(s);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        mode  = 1'b0;
`ifdef SWEEP_CHECK_EN
        exp_y1 = 16'hF000;
        exp_y2 = 16'hEEEE;
`endif
        repeat (2) step();
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_vec", vec0, 4'd0);
        chk("rst_abcd", {a0, b0, c0, d0}, 4'd0);
        chk("rst_tt", {tt1_0, tt2_0}, 32'd0);
        #2 rst = 1'b0;
        step();

        // Basic sweep with AND/OR stub
        sweep(2, 16'hF000, 16'hEEEE);
        step();
        chk("done_pulse", cur_done, 1'b0);
        chk("idle_tt1", cur_tt1, 16'hF000);

        // Vector sequencing with SETTLE_CYC=1
        sel = 1'b1;
        sweep(1, 16'hF000, 16'hEEEE);
        repeat (2) step();
        chk("s1_rest_abcd", cur_abcd, 4'hF);
        sel = 1'b0;

        // Start held high: back-to-back sweeps
        mode = 1'b1;
        sb_q.push_back(exp_t'({16'hFFFF, 16'h0000}));
        start = 1'b1;
        step();
        watch(2);
        step();
        chk("hold_idle_busy", cur_busy, 1'b0);
        chk("hold_idle_tt1", cur_tt1, 16'hFFFF);
        mode = 1'b0;
        sb_q.push_back(exp_t'({16'hF000, 16'hEEEE}));
        step();
        start = 1'b0;
        chk("hold_restart_busy", cur_busy, 1'b1);
        chk("hold_clear_tt", {cur_tt1, cur_tt2}, 32'd0);
        watch(2);
        step();

        // Asynchronous reset mid-sweep at vector 7
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (cur_vec !== 4'd7 && n < 200) begin
            step();
            n++;
        end
        chk("reach_vec7", cur_vec, 4'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", cur_busy, 1'b0);
        chk("arst_done", cur_done, 1'b0);
        chk("arst_vec", cur_vec, 4'd0);
        chk("arst_abcd", cur_abcd, 4'd0);
        chk("arst_tt", {cur_tt1, cur_tt2}, 32'd0);
        repeat (3) begin
            step();
            chk("arst_no_done", cur_done, 1'b0);
        end
        #2 rst = 1'b0;
        step();
        sweep(2, 16'hF000, 16'hEEEE);
        step();

        // Constant stub, two sweeps, results visible while idle
        mode = 1'b1;
        sweep(2, 16'hFFFF, 16'h0000);
        repeat (3) step();
        chk("idle_hold_tt1", cur_tt1, 16'hFFFF);
        chk("idle_hold_tt2", cur_tt2, 16'h0000);
        sweep(2, 16'hFFFF, 16'h0000);
        step();
        mode = 1'b0;

`ifdef SWEEP_CHECK_EN
        exp_y1 = 16'hF001;
        exp_y2 = 16'hEEEE;
        sweep(2, 16'hF000, 16'hEEEE);
        chk("chk_mismatch", mm0, 1'b1);
        chk("chk_fail_idx", fidx0, 4'd0);
        chk("chk_fail_cnt", fcnt0, 5'd1);
        step();
        chk("chk_mismatch_hold", mm0, 1'b1);
        exp_y1 = 16'hF000;
        sweep(2, 16'hF000, 16'hEEEE);
        chk("chk_clean_mismatch", mm0, 1'b0);
        chk("chk_clean_cnt", fcnt0, 5'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/comb_logic_sweeper.md
Name: comb_logic_sweeper

Overview:
Sequencer that exhaustively drives the 4-input comb_logic datapath (A, B, C, D -> Y1, Y2) through all 16 input vectors. It holds each vector for a programmable settle time, samples Y1/Y2, and assembles two 16-bit truth-table registers. Start/busy/done handshake to a host controller. Sits between the host and one comb_logic instance; its A..D outputs wire directly to the instance inputs.

Parameters:
SETTLE_CYC, 2, cycles each vector is held before the sample cycle; legal range 1..15
CNT_W, 4, settle counter width; must hold SETTLE_CYC

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
A  output  1  datapath input A, registered, = vec_idx[3]
B  output  1  datapath input B, registered, = vec_idx[2]
C  output  1  datapath input C, registered, = vec_idx[1]
D  output  1  datapath input D, registered, = vec_idx[0]
Y1  input  1  datapath output Y1
Y2  input  1  datapath output Y2
busy  output  1  high in SETTLE and SAMPLE
done  output  1  one-cycle pulse when sweep completes
vec_idx  output  4  current vector index
tt_y1  output  16  bit i = Y1 sampled with vector i
tt_y2  output  16  bit i = Y2 sampled with vector i

Behaviour:
- Reset (async, immediate, also mid-sweep): state=IDLE, A=B=C=D=0, vec_idx=0, settle cnt=0, busy=0, done=0, tt_y1=tt_y2=16'h0000.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> SETTLE; vec_idx=0, cnt=0, tt_y1=tt_y2=0. start=0 -> stay. tt registers hold the previous sweep result while idle.
- {A,B,C,D} is always registered from vec_idx; A is the MSB.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYC-1 -> SAMPLE, cnt=0.
- SAMPLE: one cycle. At its closing edge, tt_y1[vec_idx]<=Y1 and tt_y2[vec_idx]<=Y2.
  - vec_idx==15 -> DONE.
  - Otherwise vec_idx<=vec_idx+1 -> SETTLE.
- Each vector is held exactly SETTLE_CYC+1 cycles. busy is high for 16*(SETTLE_CYC+1) cycles.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. vec_idx stays 15 and {A,B,C,D}=4'hF until the next start.
- start while busy or in DONE is ignored; there is no queuing.
- Latency: if start is sampled at edge 0, done is high in cycle 16*(SETTLE_CYC+1)+1. A new start may be accepted in the cycle after done.
- Only Y1/Y2 present during a SAMPLE cycle are ever captured.

Optional Feature:
Macro SWEEP_CHECK_EN.
- Defined:
  - Adds inputs exp_y1[15:0] and exp_y2[15:0], sampled at start acceptance and held internally.
  - Adds outputs mismatch (1), fail_idx (4) and fail_cnt (5).
  - In each SAMPLE, if Y1!=exp_y1[vec_idx] or Y2!=exp_y2[vec_idx]: fail_cnt increments. On the first failure only, fail_idx<=vec_idx.
  - mismatch is set at the DONE cycle if fail_cnt!=0, and holds until the next start or rst.
  - All three outputs reset to 0 and clear on start.
- Undefined: these ports and the compare logic are absent; the core behaviour is identical.

Test Plan:
- Bench stub Y1=A&B, Y2=C|D, SETTLE_CYC=2, pulse start -> done at cycle 49 after start; tt_y1=16'hF000, tt_y2=16'hEEEE; busy high for exactly 48 cycles.
- Vector sequencing, SETTLE_CYC=1 -> {A,B,C,D} steps 0,1,...,15, each held 2 cycles. After done it rests at 4'hF.
- Hold start high continuously -> first sweep completes. The next sweep starts the cycle after done, and tt registers clear to 0 at that start.
- Assert rst at vector 7 mid-sweep -> all outputs 0 immediately (async, no clock edge needed). No done pulse. A fresh start then gives a full correct sweep.
- Stub Y1=1, Y2=0 constant -> tt_y1=16'hFFFF, tt_y2=16'h0000. A second sweep gives the same values, and previous results are visible while IDLE.
- SWEEP_CHECK_EN defined, stub Y1=A&B, exp_y1=16'hF001, exp_y2=16'hEEEE -> mismatch=1, fail_idx=0, fail_cnt=1. With exp_y1=16'hF000 -> mismatch=0, fail_cnt=0.
